// File: rtl/cson_pkg.sv
// Shared fetch-path definitions: fetch FSM state encoding, instruction width, PC step.
package cson_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_e;

  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;

endpackage

// File: rtl/ifetch_ctrl_if.sv
// Fetch-path bus: instruction memory req/ack on one side, IR load and redirect on the other.
interface ifetch_ctrl_if
  import cson_pkg::*;
#(
  parameter int ADDR_W = 32
);
  // imem: req/addr stay stable from the cycle req rises until the cycle ack=1, and the
  // transfer completes in exactly that cycle. IR: head transfers when W_IR_valid & ir_ready.
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] I;
  logic [ADDR_W-1:0]  pc;
  logic               W_IR_valid;
  logic               ir_ready;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               busy;

  modport master (
    output imem_req, imem_addr, I, pc, W_IR_valid, busy,
    input  imem_ack, imem_rdata, ir_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, I, pc, W_IR_valid, busy,
    output imem_ack, imem_rdata, ir_ready, redirect, redirect_pc
  );

endinterface

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO holding {pc, instr} pairs; flush wins over push and pop.
module ifetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Storage is cleared on reset so the head reads as zero straight out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch address, buffers words, flushes on redirect.
// Optional IFETCH_PERF_CNT_EN adds saturating fetch/stall performance counters.
module ifetch_ctrl
  import cson_pkg::*;
#(
  parameter int               ADDR_W     = 32,
  parameter int               FIFO_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic          clk,
  input  logic          rst,
  ifetch_ctrl_if.master bus,
  output fetch_state_e  state_dbg
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]   perf_fetch_cnt,
  output logic [31:0]   perf_stall_cnt
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = ADDR_W + INSTR_W;

  fetch_state_e      state;
  logic [ADDR_W-1:0] fa;
  logic [ADDR_W-1:0] drop_addr;
  logic [ADDR_W-1:0] target;
  logic [EW-1:0]     head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_cnt;
  logic [CW-1:0]     next_cnt;
  logic              push;
  logic              pop;
  logic              ack_ok;

  assign target          = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
  assign bus.imem_req    = (state == ST_REQ) || (state == ST_DROP);
  assign bus.busy        = bus.imem_req;
  // In DROP the abandoned request must stay on the bus while fa already holds the target.
  assign bus.imem_addr   = (state == ST_DROP) ? drop_addr : fa;
  assign bus.W_IR_valid  = ~fifo_empty & ~bus.redirect;
  assign bus.I           = head[INSTR_W-1:0];
  assign bus.pc          = head[EW-1:INSTR_W];
  assign ack_ok          = bus.imem_req & bus.imem_ack;
  assign push            = (state == ST_REQ) & bus.imem_ack & ~bus.redirect & ~fifo_full;
  assign pop             = bus.W_IR_valid & bus.ir_ready;
  assign next_cnt        = fifo_cnt + CW'(push) - CW'(pop);
  assign state_dbg       = state;

  ifetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect),
    .din   ({fa, bus.imem_rdata}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      fa        <= RESET_PC;
      drop_addr <= '0;
    end else if (bus.redirect) begin
      fa <= target;
      case (state)
        ST_REQ: begin
          if (!bus.imem_ack) begin
            state     <= ST_DROP;
            drop_addr <= fa;
          end
        end
        ST_IDLE, ST_HOLD: state <= ST_REQ;
        default: state <= state;
      endcase
    end else begin
      case (state)
        ST_IDLE: state <= ST_REQ;
        ST_REQ: begin
          if (bus.imem_ack) begin
            fa <= fa + ADDR_W'(PC_STEP);
            if (next_cnt == CW'(FIFO_DEPTH)) state <= ST_HOLD;
          end
        end
        ST_HOLD: if (next_cnt < CW'(FIFO_DEPTH)) state <= ST_REQ;
        ST_DROP: if (bus.imem_ack) state <= ST_REQ;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (ack_ok && (perf_fetch_cnt != '1)) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (bus.ir_ready && !bus.W_IR_valid && (perf_stall_cnt != '1))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`else
  logic unused_ack_ok;
  assign unused_ack_ok = ack_ok;
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: streaming, FIFO-full hold, redirect cases, wrap, async reset.
module tb_ifetch_ctrl;
  import cson_pkg::*;

  localparam int ADDR_W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  fetch_state_e state_dbg;
  int           n_cmp = 0;
  int           n_err = 0;
  logic [31:0]  exp_q[$];
  logic [31:0]  exp_pc;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0]  perf_fetch_cnt;
  logic [31:0]  perf_stall_cnt;
`endif

  ifetch_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  ifetch_ctrl #(
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (2),
    .RESET_PC   ('0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Instruction memory model: word content is a fixed function of its address.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction
  assign bus.imem_rdata = word_at(bus.imem_addr);

  // Scoreboard check
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ack, input logic rdy, input logic redir, input logic [31:0] rpc);
    bus.imem_ack    = ack;
    bus.ir_ready    = rdy;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
  endtask

  // Returns just after the releasing edge+1: the current cycle is cycle 0 (IDLE).
  task automatic do_reset();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (2) next_cycle();
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    n_err++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'h0);

    // 1: streaming with ack=1 and ir_ready=1
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    check_val("rst_req",   32'(bus.imem_req),   32'd0);
    check_val("rst_busy",  32'(bus.busy),       32'd0);
    check_val("rst_valid", 32'(bus.W_IR_valid), 32'd0);
    check_val("rst_I",     bus.I,               32'd0);
    check_val("rst_pc",    bus.pc,              32'd0);
    check_val("rst_state", 32'(state_dbg),      32'(ST_IDLE));
`ifdef IFETCH_PERF_CNT_EN
    check_val("rst_perf_fetch", perf_fetch_cnt, 32'd0);
    check_val("rst_perf_stall", perf_stall_cnt, 32'd0);
`endif
    for (int i = 0; i < 5; i++) exp_q.push_back(32'(4 * i));
    for (int k = 1; k <= 6; k++) begin
      next_cycle();
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      check_val("t1_req",   32'(bus.imem_req),   32'd1);
      check_val("t1_addr",  bus.imem_addr,       32'(4 * (k - 1)));
      check_val("t1_valid", 32'(bus.W_IR_valid), 32'(k >= 2));
      if (k >= 2) begin
        exp_pc = exp_q.pop_front();
        check_val("t1_pc", bus.pc, exp_pc);
        check_val("t1_I",  bus.I,  word_at(exp_pc));
      end
    end
`ifdef IFETCH_PERF_CNT_EN
    check_val("t1_perf_fetch", perf_fetch_cnt, 32'd5);
    check_val("t1_perf_stall", perf_stall_cnt, 32'd2);
`endif

    // 2: ir_ready=0 fills the FIFO, then HOLD; one pop resumes fetching at 8
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    next_cycle(); @(negedge clk);
    check_val("t2_req_c1",  32'(bus.imem_req), 32'd1);
    check_val("t2_addr_c1", bus.imem_addr,     32'h0);
    next_cycle(); @(negedge clk);
    check_val("t2_addr_c2", bus.imem_addr,     32'h4);
    next_cycle(); @(negedge clk);
    check_val("t2_req_c3",   32'(bus.imem_req),   32'd0);
    check_val("t2_state_c3", 32'(state_dbg),      32'(ST_HOLD));
    check_val("t2_valid_c3", 32'(bus.W_IR_valid), 32'd1);
    check_val("t2_pc_c3",    bus.pc,              32'h0);
    next_cycle(); @(negedge clk);
    check_val("t2_req_c4", 32'(bus.imem_req), 32'd0);
    next_cycle(); drive(1'b1, 1'b1, 1'b0, 32'h0); @(negedge clk);
    check_val("t2_req_c5", 32'(bus.imem_req), 32'd0);
    check_val("t2_pc_c5",  bus.pc,            32'h0);
    next_cycle(); drive(1'b1, 1'b0, 1'b0, 32'h0); @(negedge clk);
    check_val("t2_req_c6",  32'(bus.imem_req), 32'd1);
    check_val("t2_addr_c6", bus.imem_addr,     32'h8);
    check_val("t2_pc_c6",   bus.pc,            32'h4);
    next_cycle(); @(negedge clk);
    check_val("t2_req_c7", 32'(bus.imem_req), 32'd0);

    // 3: redirect to 0x103 with ack held low: stale request completes and is dropped
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    next_cycle(); drive(1'b0, 1'b1, 1'b1, 32'h0000_0103); @(negedge clk);
    check_val("t3_addr_c1",  bus.imem_addr,       32'h0);
    check_val("t3_valid_c1", 32'(bus.W_IR_valid), 32'd0);
    next_cycle(); drive(1'b0, 1'b1, 1'b0, 32'h0); @(negedge clk);
    check_val("t3_state_c2", 32'(state_dbg), 32'(ST_DROP));
    check_val("t3_busy_c2",  32'(bus.busy),  32'd1);
    check_val("t3_addr_c2",  bus.imem_addr,  32'h0);
    next_cycle(); @(negedge clk);
    check_val("t3_addr_c3", bus.imem_addr, 32'h0);
    next_cycle(); drive(1'b1, 1'b1, 1'b0, 32'h0); @(negedge clk);
    check_val("t3_addr_c4", bus.imem_addr, 32'h0);
    next_cycle(); drive(1'b1, 1'b0, 1'b0, 32'h0); @(negedge clk);
    check_val("t3_addr_c5",  bus.imem_addr,       32'h100);
    check_val("t3_valid_c5", 32'(bus.W_IR_valid), 32'd0);
    next_cycle(); drive(1'b0, 1'b0, 1'b0, 32'h0); @(negedge clk);
    check_val("t3_valid_c6", 32'(bus.W_IR_valid), 32'd1);
    check_val("t3_pc_c6",    bus.pc,              32'h100);
    check_val("t3_I_c6",     bus.I,               word_at(32'h100));

    // 4: redirect in the same cycle as ack and a would-be pop
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    next_cycle(); @(negedge clk);
    next_cycle(); @(negedge clk);
    check_val("t4_pc_c2", bus.pc, 32'h0);
    next_cycle(); drive(1'b1, 1'b1, 1'b1, 32'h0000_0200); @(negedge clk);
    check_val("t4_valid_c3", 32'(bus.W_IR_valid), 32'd0);
    next_cycle(); drive(1'b0, 1'b1, 1'b0, 32'h0); @(negedge clk);
    check_val("t4_valid_c4", 32'(bus.W_IR_valid), 32'd0);
    check_val("t4_addr_c4",  bus.imem_addr,       32'h200);
    next_cycle(); drive(1'b1, 1'b1, 1'b0, 32'h0); @(negedge clk);
    check_val("t4_addr_c5", bus.imem_addr, 32'h200);
    next_cycle(); @(negedge clk);
    check_val("t4_pc_c6",   bus.pc,        32'h200);
    check_val("t4_addr_c6", bus.imem_addr, 32'h204);

    // 5: address wraps from 0xFFFFFFFC to 0
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    next_cycle(); drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE); @(negedge clk);
    check_val("t5_addr_c1", bus.imem_addr, 32'h0);
    next_cycle(); drive(1'b1, 1'b1, 1'b0, 32'h0); @(negedge clk);
    check_val("t5_addr_c2",  bus.imem_addr,       32'hFFFF_FFFC);
    check_val("t5_valid_c2", 32'(bus.W_IR_valid), 32'd0);
    next_cycle(); @(negedge clk);
    check_val("t5_addr_c3", bus.imem_addr, 32'h0);
    check_val("t5_pc_c3",   bus.pc,        32'hFFFF_FFFC);
    next_cycle(); @(negedge clk);
    check_val("t5_addr_c4", bus.imem_addr, 32'h4);
    check_val("t5_pc_c4",   bus.pc,        32'h0);

    // 6: asynchronous reset in the middle of a request
    next_cycle(); drive(1'b0, 1'b1, 1'b0, 32'h0); @(negedge clk);
    check_val("t6_req_pre", 32'(bus.imem_req), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_val("t6_req_async",   32'(bus.imem_req),   32'd0);
    check_val("t6_busy_async",  32'(bus.busy),       32'd0);
    check_val("t6_valid_async", 32'(bus.W_IR_valid), 32'd0);
    check_val("t6_pc_async",    bus.pc,              32'd0);
    check_val("t6_I_async",     bus.I,               32'd0);
    next_cycle();
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'h0);
`ifdef IFETCH_PERF_CNT_EN
    @(negedge clk);
    check_val("t6_perf_fetch", perf_fetch_cnt, 32'd0);
    check_val("t6_perf_stall", perf_stall_cnt, 32'd0);
`endif
    next_cycle(); @(negedge clk);
    check_val("t6_req_c1",  32'(bus.imem_req), 32'd1);
    check_val("t6_addr_c1", bus.imem_addr,     32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
